// File: rtl/audio_frame_mux_if.sv
// Frame output handshake between the source mux and the DAC path.
// master: out_valid/out_l/out_r out, out_ready in; slave is the mirror.
interface audio_frame_mux_if #(
  parameter int DATA_W = 24
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_l;
  logic [DATA_W-1:0] out_r;

  modport master (
    output out_valid,
    output out_l,
    output out_r,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_l,
    input  out_r,
    output out_ready
  );
endinterface

// File: rtl/audio_frame_mux.sv
// Stereo source selector: pairs L/R strobes of active_sel into frames,
// switches sources on frame boundaries and buffers frames in a FWFT FIFO.
// Ports: clk, reset (async, high), run, select, mute, src_{l,r}_{en,d},
// out_if (valid/ready frame output), active_sel, fifo_level, overflow_cnt.
module audio_frame_mux #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int SEL_W      = $clog2(NUM_SRC),
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic [SEL_W-1:0]          select,
  input  logic                      mute,
  input  logic [NUM_SRC-1:0]        src_l_en,
  input  logic [NUM_SRC-1:0]        src_r_en,
  input  logic [NUM_SRC*DATA_W-1:0] src_l_d,
  input  logic [NUM_SRC*DATA_W-1:0] src_r_d,
  audio_frame_mux_if.master         out_if,
  output logic [SEL_W-1:0]          active_sel,
  output logic [LVL_W-1:0]          fifo_level,
  output logic [7:0]                overflow_cnt
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic [SEL_W-1:0]    sel_q;
  logic                l_have;
  logic                r_have;
  logic [DATA_W-1:0]   l_hold;
  logic [DATA_W-1:0]   r_hold;
  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [LVL_W-1:0]    wr_ptr;
  logic [LVL_W-1:0]    rd_ptr;
  logic [7:0]          ovf_q;
  logic [DATA_W-1:0]   head_l;
  logic [DATA_W-1:0]   head_r;

  logic                sel_ok;
  logic                do_switch;
  logic                l_en_a;
  logic                r_en_a;
  logic [DATA_W-1:0]   l_d_a;
  logic [DATA_W-1:0]   r_d_a;
  logic                l_stb;
  logic                r_stb;
  logic                push;
  logic                pop;
  logic                wr_en;
  logic [LVL_W-1:0]    level;
  logic [LVL_W-1:0]    rd_nxt;
  logic                empty;
  logic                full;
  logic [2*DATA_W-1:0] frame;

  always_comb begin
    l_en_a = 1'b0;
    r_en_a = 1'b0;
    l_d_a  = '0;
    r_d_a  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_q == SEL_W'(i)) begin
        l_en_a = src_l_en[i];
        r_en_a = src_r_en[i];
        l_d_a  = src_l_d[i*DATA_W +: DATA_W];
        r_d_a  = src_r_d[i*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_ok    = {1'b0, select} < (SEL_W+1)'(NUM_SRC);
  assign do_switch = sel_ok && (select != sel_q);

  // Strobes in a switch cycle belong to the old source: dropped.
  assign l_stb = run && !do_switch && l_en_a;
  assign r_stb = run && !do_switch && r_en_a;
  assign push  = run && l_have && r_have;

  assign level  = wr_ptr - rd_ptr;
  assign empty  = (level == '0);
  assign full   = (level == FULL_LVL);
  assign rd_nxt = rd_ptr + ONE;
  assign pop    = run && !empty && out_if.out_ready;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign wr_en  = push && (!full || pop);
  assign frame  = mute ? '0 : {l_hold, r_hold};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q  <= '0;
      l_have <= 1'b0;
      r_have <= 1'b0;
      l_hold <= '0;
      r_hold <= '0;
    end else begin
      if (do_switch) sel_q <= select;
      if (l_stb) l_hold <= l_d_a;
      if (r_stb) r_hold <= r_d_a;
      if (!run || do_switch) begin
        l_have <= 1'b0;
        r_have <= 1'b0;
      end else begin
        // A strobe in the push cycle opens the next frame.
        if (l_stb)     l_have <= 1'b1;
        else if (push) l_have <= 1'b0;
        if (r_stb)     r_have <= 1'b1;
        else if (push) r_have <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= frame;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= '0;
      head_l <= '0;
      head_r <= '0;
    end else if (!run) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      if (pop)   rd_ptr <= rd_nxt;
      if (push && full && !pop && ovf_q != 8'hFF)
        ovf_q <= ovf_q + 8'd1;
      // Head register mirrors mem[rd_ptr]; it only moves on
      // a push into empty or a pop, otherwise it holds.
      if (wr_en && empty) begin
        {head_l, head_r} <= frame;
      end else if (pop) begin
        if (level > ONE)
          {head_l, head_r} <= mem[rd_nxt[ADDR_W-1:0]];
        else if (wr_en)
          {head_l, head_r} <= frame;
      end
    end
  end

  assign out_if.out_valid = !empty;
  assign out_if.out_l     = head_l;
  assign out_if.out_r     = head_r;
  assign active_sel       = sel_q;
  assign fifo_level       = level;
  assign overflow_cnt     = ovf_q;

endmodule

// File: tb/tb_audio_frame_mux.sv
// Bench for audio_frame_mux: directed cases plus random traffic,
// checked by a queue-based reference model and a negedge monitor.
module tb_audio_frame_mux;
  localparam int NUM_SRC    = 4;
  localparam int DATA_W     = 24;
  localparam int FIFO_DEPTH = 4;
  localparam int SEL_W      = $clog2(NUM_SRC);
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      run = 1'b0;
  logic                      mute = 1'b0;
  logic [SEL_W-1:0]          select = '0;
  logic [NUM_SRC-1:0]        src_l_en = '0;
  logic [NUM_SRC-1:0]        src_r_en = '0;
  logic [NUM_SRC*DATA_W-1:0] src_l_d = '0;
  logic [NUM_SRC*DATA_W-1:0] src_r_d = '0;
  logic [SEL_W-1:0]          active_sel;
  logic [LVL_W-1:0]          fifo_level;
  logic [7:0]                overflow_cnt;

  audio_frame_mux_if #(.DATA_W(DATA_W)) out_if ();

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  audio_frame_mux #(
    .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .select(select),
    .mute(mute), .src_l_en(src_l_en), .src_r_en(src_r_en),
    .src_l_d(src_l_d), .src_r_d(src_r_d), .out_if(out_if),
    .active_sel(active_sel), .fifo_level(fifo_level),
    .overflow_cnt(overflow_cnt)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: frames queue, pending half-frames, drop counter.
  logic [2*DATA_W-1:0] fq[$];
  int                  m_ovf;
  int                  m_sel;
  bit                  m_lh, m_rh;
  logic [DATA_W-1:0]   m_l, m_r;

  always @(posedge clk or posedge reset) begin : model
    bit sw, pu, po;
    if (reset) begin
      fq.delete();
      m_ovf = 0; m_sel = 0;
      m_lh = 0; m_rh = 0; m_l = '0; m_r = '0;
    end else begin
      sw = (int'(select) < NUM_SRC) && (int'(select) != m_sel);
      pu = run && m_lh && m_rh;
      po = run && fq.size() > 0 && out_if.out_ready;
      if (!run) fq.delete();
      else begin
        if (po) void'(fq.pop_front());
        if (pu) begin
          if (fq.size() < FIFO_DEPTH)
            fq.push_back(mute ? '0 : {m_l, m_r});
          else if (m_ovf < 255)
            m_ovf++;
        end
      end
      if (pu) begin m_lh = 0; m_rh = 0; end
      if (run && !sw) begin
        if (src_l_en[m_sel]) begin
          m_lh = 1; m_l = src_l_d[m_sel*DATA_W +: DATA_W];
        end
        if (src_r_en[m_sel]) begin
          m_rh = 1; m_r = src_r_d[m_sel*DATA_W +: DATA_W];
        end
      end
      if (!run || sw) begin m_lh = 0; m_rh = 0; end
      if (sw) m_sel = int'(select);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("valid", 64'(out_if.out_valid), 64'(fq.size() != 0));
      chk("level", 64'(fifo_level), 64'(fq.size()));
      chk("ovf", 64'(overflow_cnt), 64'(m_ovf));
      chk("asel", 64'(active_sel), 64'(m_sel));
      if (out_if.out_valid && fq.size() != 0)
        chk("head", 64'({out_if.out_l, out_if.out_r}), 64'(fq[0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_SRC; i++) begin
      src_l_d[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      src_r_d[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
  endtask

  task automatic strobe(int s, bit l, bit r,
                        logic [DATA_W-1:0] lv,
                        logic [DATA_W-1:0] rv);
    rand_data();
    if (l) begin
      src_l_en[s] = 1'b1;
      src_l_d[s*DATA_W +: DATA_W] = lv;
    end
    if (r) begin
      src_r_en[s] = 1'b1;
      src_r_d[s*DATA_W +: DATA_W] = rv;
    end
    step();
    src_l_en = '0;
    src_r_en = '0;
  endtask

  task automatic drain();
    out_if.out_ready = 1'b1;
    idle(FIFO_DEPTH + 1);
    out_if.out_ready = 1'b0;
    chk("drained", 64'(fifo_level), 64'(0));
  endtask

  task automatic reset_vals(string tag);
    chk({tag, "_valid"}, 64'(out_if.out_valid), 64'(0));
    chk({tag, "_l"}, 64'(out_if.out_l), 64'(0));
    chk({tag, "_r"}, 64'(out_if.out_r), 64'(0));
    chk({tag, "_lvl"}, 64'(fifo_level), 64'(0));
    chk({tag, "_ovf"}, 64'(overflow_cnt), 64'(0));
    chk({tag, "_asel"}, 64'(active_sel), 64'(0));
  endtask

  initial begin
    out_if.out_ready = 1'b0;
    #1;
    reset_vals("rst");
    step();
    reset = 1'b0;
    run = 1'b1;

    // Basic frame, R three cycles after L.
    select = 2'd2;
    step();
    strobe(2, 1, 0, 24'h123456, 24'h0);
    idle(2);
    strobe(2, 0, 1, 24'h0, 24'h654321);
    chk("basic_lat", 64'(out_if.out_valid), 64'(0));
    step();
    chk("basic_valid", 64'(out_if.out_valid), 64'(1));
    chk("basic_l", 64'(out_if.out_l), 64'h123456);
    chk("basic_r", 64'(out_if.out_r), 64'h654321);
    chk("basic_lvl", 64'(fifo_level), 64'(1));
    out_if.out_ready = 1'b1;
    step();
    out_if.out_ready = 1'b0;
    chk("basic_pop", 64'(fifo_level), 64'(0));

    // Foreign sources only.
    strobe(0, 1, 1, 24'h1, 24'h2);
    strobe(1, 1, 1, 24'h3, 24'h4);
    strobe(3, 1, 1, 24'h5, 24'h6);
    idle(2);
    chk("foreign", 64'(fifo_level), 64'(0));

    // Simultaneous L and R.
    strobe(2, 1, 1, 24'hABCDEF, 24'h0FEDCB);
    step();
    chk("simul_lvl", 64'(fifo_level), 64'(1));
    chk("simul_l", 64'(out_if.out_l), 64'hABCDEF);
    drain();

    // Duplicate left: latest wins.
    strobe(2, 1, 0, 24'h000001, 24'h0);
    strobe(2, 1, 0, 24'h000002, 24'h0);
    strobe(2, 0, 1, 24'h0, 24'h000003);
    step();
    chk("dup_l", 64'(out_if.out_l), 64'h000002);
    chk("dup_r", 64'(out_if.out_r), 64'h000003);
    drain();

    // Switch mid-frame discards the partial frame.
    select = 2'd0;
    step();
    strobe(0, 1, 0, 24'h111111, 24'h0);
    select = 2'd1;
    step();
    strobe(0, 0, 1, 24'h0, 24'h222222);
    idle(3);
    chk("sw_none", 64'(fifo_level), 64'(0));
    strobe(1, 1, 1, 24'hC0FFEE, 24'hBEEF01);
    step();
    chk("sw_asel", 64'(active_sel), 64'(1));
    chk("sw_l", 64'(out_if.out_l), 64'hC0FFEE);
    chk("sw_r", 64'(out_if.out_r), 64'hBEEF01);
    drain();

    // Overflow: six frames into four slots.
    select = 2'd2;
    step();
    for (int k = 0; k < 6; k++)
      strobe(2, 1, 1, DATA_W'(24'h100 + k), DATA_W'(24'h200 + k));
    step();
    chk("ovf_lvl", 64'(fifo_level), 64'(4));
    chk("ovf_cnt", 64'(overflow_cnt), 64'(2));
    chk("ovf_head", 64'({out_if.out_l, out_if.out_r}), 64'h000100000200);
    strobe(2, 1, 1, 24'h300, 24'h400);
    out_if.out_ready = 1'b1;
    step();
    out_if.out_ready = 1'b0;
    chk("full_pp_lvl", 64'(fifo_level), 64'(4));
    chk("full_pp_ovf", 64'(overflow_cnt), 64'(2));
    chk("full_pp_head", 64'(out_if.out_l), 64'h101);
    drain();

    // Mute zeroes the pushed frame.
    mute = 1'b1;
    strobe(2, 1, 1, 24'hAAAAAA, 24'hBBBBBB);
    step();
    mute = 1'b0;
    chk("mute_lvl", 64'(fifo_level), 64'(1));
    chk("mute_lr", 64'({out_if.out_l, out_if.out_r}), 64'(0));
    drain();

    // Run drop flushes three stored frames.
    for (int k = 0; k < 3; k++)
      strobe(2, 1, 1, DATA_W'(k + 7), DATA_W'(k + 9));
    step();
    chk("run_lvl3", 64'(fifo_level), 64'(3));
    run = 1'b0;
    step();
    chk("run_valid", 64'(out_if.out_valid), 64'(0));
    chk("run_lvl", 64'(fifo_level), 64'(0));
    chk("run_ovf", 64'(overflow_cnt), 64'(2));
    run = 1'b1;
    step();

    // Reset mid-frame with a frame stored.
    strobe(2, 1, 1, 24'h55, 24'h66);
    step();
    strobe(2, 1, 0, 24'h77, 24'h0);
    #1;
    reset = 1'b1;
    #1;
    reset_vals("mid_rst");
    step();
    reset = 1'b0;
    step();
    strobe(2, 0, 1, 24'h0, 24'h88);
    idle(3);
    chk("post_rst", 64'(fifo_level), 64'(0));

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rand_data();
      src_l_en = NUM_SRC'($urandom);
      src_r_en = NUM_SRC'($urandom);
      out_if.out_ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 25) == 0) select = SEL_W'($urandom);
      mute = ($urandom_range(0, 15) == 0);
      run = ($urandom_range(0, 80) != 0);
      step();
    end
    src_l_en = '0;
    src_r_en = '0;
    mute = 1'b0;
    run = 1'b1;
    idle(2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
